// File: rtl/pe_act_receive_fsm_pkg.sv
// ============================================================================
// Module      : pe_act_receive_fsm_pkg
// Description : Shared types and packet-decode helpers for the PE activation
//               receive path (state encoding, router field layout).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pe_act_receive_fsm_pkg;

    localparam int ROUTER_ADDR_WIDTH = 16;
    localparam int SRC_W             = 6;
    localparam int CMP_BIT           = ROUTER_ADDR_WIDTH - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Completion packets carry their source in the data field, activations in the address.
    function automatic logic [SRC_W-1:0] pkt_src(
        input logic [ROUTER_ADDR_WIDTH-1:0] addr,
        input logic [SRC_W-1:0]             cmp_src
    );
        return addr[CMP_BIT] ? cmp_src : addr[SRC_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/pe_recv_fifo.sv
// ============================================================================
// Module      : pe_recv_fifo
// Description : Synchronous FIFO of {addr,data} router packets, power-of-2 depth.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_recv_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = $clog2(DEPTH) + 1;

    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + PW'(1);
            if (pop_i)  rptr_q <= rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q[PW-2:0]] <= wr_data_i;
    end

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign rd_data_o = mem_q[rptr_q[PW-2:0]];
    assign empty_o   = (wptr_q == rptr_q);
    assign full_o    = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[PW-2:0] == rptr_q[PW-2:0]);

endmodule

`default_nettype wire

// File: rtl/pe_act_receive_fsm.sv
// ============================================================================
// Module      : pe_act_receive_fsm
// Description : Receive side of the PE activation broadcast: buffers router
//               packets, writes activations, tracks per-source completion.
//               Optional macro PE_RECV_ERR_CHK_EN builds the sticky recv_err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_act_receive_fsm
    import pe_act_receive_fsm_pkg::*;
#(
    parameter int PE_IDX     = 0,
    parameter int NUM_PE     = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MEM_AW     = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pe_start_calc,
    input  logic [NUM_PE-1:0]            expect_mask,
    input  logic                         recv_valid,
    output logic                         recv_rdy,
    input  logic [ROUTER_ADDR_WIDTH-1:0] recv_addr,
    input  logic [DATA_WIDTH-1:0]        recv_data,
    output logic                         act_wr_en,
    output logic [MEM_AW-1:0]            act_wr_addr,
    output logic [DATA_WIDTH-1:0]        act_wr_data,
    input  logic                         act_wr_stall,
    output logic [CNT_WIDTH-1:0]         act_cnt,
    output logic [NUM_PE-1:0]            done_mask,
    output logic                         recv_done,
    output logic                         recv_err,
    output logic [SRC_W-1:0]             dbg_pe_idx
);

    localparam int PKT_W = ROUTER_ADDR_WIDTH + DATA_WIDTH;

    state_t                  state_q;
    logic [NUM_PE-1:0]       expect_q;
    logic [NUM_PE-1:0]       done_mask_q;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic                    wr_en_q;
    logic [MEM_AW-1:0]       wr_addr_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;
    logic                    recv_done_q;

    logic                         w_push;
    logic                         w_pop;
    logic                         w_full;
    logic                         w_empty;
    logic [PKT_W-1:0]             w_head;
    logic [ROUTER_ADDR_WIDTH-1:0] w_head_addr;
    logic [DATA_WIDTH-1:0]        w_head_data;
    logic                         w_is_cmp;
    logic [SRC_W-1:0]             w_src;
    logic [NUM_PE-1:0]            w_src_oh;
    logic                         w_src_ok;
    logic                         w_act_pop;
    logic                         w_cmp_pop;
    logic                         w_all_done;
    logic                         w_start;
    logic [ROUTER_ADDR_WIDTH-2:0] w_full_addr;

    // A phase with nothing expected completes immediately, so it never opens the port.
    assign recv_rdy = (state_q == ST_RECV) & ~w_full & (|expect_q);
    assign w_push   = recv_valid & recv_rdy;

    pe_recv_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (w_push),
        .wr_data_i ({recv_addr, recv_data}),
        .pop_i     (w_pop),
        .rd_data_o (w_head),
        .full_o    (w_full),
        .empty_o   (w_empty)
    );

    assign w_head_addr = w_head[PKT_W-1:DATA_WIDTH];
    assign w_head_data = w_head[DATA_WIDTH-1:0];
    assign w_is_cmp    = w_head_addr[CMP_BIT];
    assign w_src       = pkt_src(w_head_addr, w_head_data[SRC_W-1:0]);
    assign w_src_oh    = NUM_PE'(1) << w_src;
    assign w_src_ok    = |w_src_oh;
    assign w_full_addr = {w_head_addr[ROUTER_ADDR_WIDTH-2:SRC_W], w_src};

    // Only a valid activation waits on the memory; everything else drains freely.
    assign w_pop      = ~w_empty & (w_is_cmp | ~w_src_ok | ~act_wr_stall);
    assign w_act_pop  = w_pop & ~w_is_cmp & w_src_ok;
    assign w_cmp_pop  = w_pop & w_is_cmp & w_src_ok;
    assign w_all_done = ((done_mask_q & expect_q) == expect_q) & w_empty & ~wr_en_q;
    assign w_start    = pe_start_calc & (state_q != ST_RECV);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            expect_q    <= '0;
            done_mask_q <= '0;
            cnt_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            recv_done_q <= 1'b0;
        end else begin
            if (w_act_pop) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= MEM_AW'(w_full_addr);
                wr_data_q <= w_head_data;
                if (~&cnt_q) cnt_q <= cnt_q + CNT_WIDTH'(1);
            end else if (!act_wr_stall) begin
                wr_en_q <= 1'b0;
            end

            if (w_cmp_pop) done_mask_q <= done_mask_q | w_src_oh;

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (pe_start_calc) begin
                        state_q     <= ST_RECV;
                        expect_q    <= expect_mask;
                        done_mask_q <= '0;
                        cnt_q       <= '0;
                        recv_done_q <= 1'b0;
                    end
                end
                ST_RECV: begin
                    if (w_all_done) begin
                        state_q     <= ST_DONE;
                        recv_done_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef PE_RECV_ERR_CHK_EN
    logic err_q;
    logic w_err_hit;

    assign w_err_hit = w_pop & (~w_src_ok
                              | (|(done_mask_q & w_src_oh))
                              | (w_is_cmp & ~(|(expect_q & w_src_oh))));

    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            err_q <= 1'b0;
        end else if (w_err_hit) begin
            err_q <= 1'b1;
        end
    end

    assign recv_err = err_q;
`else
    assign recv_err = 1'b0;
`endif

    assign act_wr_en   = wr_en_q;
    assign act_wr_addr = wr_addr_q;
    assign act_wr_data = wr_data_q;
    assign act_cnt     = cnt_q;
    assign done_mask   = done_mask_q;
    assign recv_done   = recv_done_q;
    assign dbg_pe_idx  = SRC_W'(PE_IDX);

endmodule

`default_nettype wire

// File: tb/tb_pe_act_receive_fsm.sv
// ============================================================================
// Module      : tb_pe_act_receive_fsm
// Description : Directed self-checking bench for pe_act_receive_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe_act_receive_fsm;

`ifdef PE_RECV_ERR_CHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pe_start_calc;
    logic [15:0] expect_mask;
    logic        recv_valid;
    logic        recv_rdy;
    logic [15:0] recv_addr;
    logic [15:0] recv_data;
    logic        act_wr_en;
    logic [9:0]  act_wr_addr;
    logic [15:0] act_wr_data;
    logic        act_wr_stall;
    logic [15:0] act_cnt;
    logic [15:0] done_mask;
    logic        recv_done;
    logic        recv_err;
    logic [5:0]  dbg_pe_idx;

    int total = 0;
    int bad   = 0;
    logic [31:0] wq_addr [$];
    logic [31:0] wq_data [$];

    pe_act_receive_fsm dut (
        .clk           (clk),
        .rst           (rst),
        .pe_start_calc (pe_start_calc),
        .expect_mask   (expect_mask),
        .recv_valid    (recv_valid),
        .recv_rdy      (recv_rdy),
        .recv_addr     (recv_addr),
        .recv_data     (recv_data),
        .act_wr_en     (act_wr_en),
        .act_wr_addr   (act_wr_addr),
        .act_wr_data   (act_wr_data),
        .act_wr_stall  (act_wr_stall),
        .act_cnt       (act_cnt),
        .done_mask     (done_mask),
        .recv_done     (recv_done),
        .recv_err      (recv_err),
        .dbg_pe_idx    (dbg_pe_idx)
    );

    always #5 clk = ~clk;

    // A write retires on the next rising edge when it is not stalled.
    always @(negedge clk) begin
        if (!rst && act_wr_en && !act_wr_stall) begin
            wq_addr.push_back({22'd0, act_wr_addr});
            wq_data.push_back({16'd0, act_wr_data});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qget(input int which, input int idx);
        if (which == 0) return (idx < wq_addr.size()) ? wq_addr[idx] : 32'hDEAD_BEEF;
        return (idx < wq_data.size()) ? wq_data[idx] : 32'hDEAD_BEEF;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_phase(input logic [15:0] m);
        expect_mask   = m;
        pe_start_calc = 1'b1;
        tick;
        pe_start_calc = 1'b0;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] d);
        int n;
        n          = 0;
        recv_valid = 1'b1;
        recv_addr  = a;
        recv_data  = d;
        while (!recv_rdy && n < 50) begin
            tick;
            n++;
        end
        if (!recv_rdy) check("send_timeout", 32'(recv_rdy), 32'd1);
        tick;
        recv_valid = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int n;
        n = 0;
        while (!recv_done && n < lim) begin
            tick;
            n++;
        end
        check("done_timeout", 32'(recv_done), 32'd1);
    endtask

    initial begin
        int base;
        int k;
        int cyc;
        logic acc;

        rst = 1'b1; pe_start_calc = 1'b0; expect_mask = '0;
        recv_valid = 1'b0; recv_addr = '0; recv_data = '0; act_wr_stall = 1'b0;
        repeat (3) tick;
        check("rst_rdy",   32'(recv_rdy),  32'd0);
        check("rst_wr_en", 32'(act_wr_en), 32'd0);
        check("rst_cnt",   32'(act_cnt),   32'd0);
        check("rst_mask",  32'(done_mask), 32'd0);
        check("rst_done",  32'(recv_done), 32'd0);
        check("rst_err",   32'(recv_err),  32'd0);
        rst = 1'b0;
        tick;

        // Single activation then both completions.
        start_phase(16'h0003);
        send(16'h0080, 16'h1234);
        check("lat_pre",  32'(act_wr_en), 32'd0);
        tick;
        check("lat_en",   32'(act_wr_en),   32'd1);
        check("lat_addr", 32'(act_wr_addr), 32'h080);
        check("lat_data", 32'(act_wr_data), 32'h1234);
        check("t1_cnt",   32'(act_cnt),     32'd1);
        send(16'h8000, 16'h0000);
        send(16'h8000, 16'h0001);
        wait_done(20);
        check("t1_mask", 32'(done_mask), 32'h0003);
        check("t1_rdy",  32'(recv_rdy),  32'd0);
        check("t1_nwr",  32'(wq_addr.size()), 32'd1);
        check("t1_addr", qget(0, 0), 32'h080);
        check("t1_data", qget(1, 0), 32'h1234);

        // Burst of 8 against a stalled memory.
        base = wq_addr.size();
        start_phase(16'h0001);
        act_wr_stall = 1'b1;
        k = 0; cyc = 0;
        recv_valid = 1'b1;
        recv_addr  = 16'((1 << 6) | 0);
        recv_data  = 16'hA000;
        while (k < 8 && cyc < 200) begin
            acc = recv_rdy;
            tick;
            cyc++;
            if (acc) begin
                k++;
                recv_addr = 16'(((k + 1) << 6) | k);
                recv_data = 16'hA000 + 16'(k);
            end
            if (cyc == 10) begin
                check("full_acc", 32'(k), 32'd4);
                check("full_rdy", 32'(recv_rdy), 32'd0);
                act_wr_stall = 1'b0;
            end
        end
        recv_valid = 1'b0;
        check("burst_acc", 32'(k), 32'd8);
        send(16'h8000, 16'h0000);
        wait_done(100);
        check("t2_nwr", 32'(wq_addr.size() - base), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("t2_addr", qget(0, base + i), 32'((((i + 1) << 6) | i) & 'h3FF));
            check("t2_data", qget(1, base + i), 32'h0000_A000 + 32'(i));
        end
        check("t2_cnt", 32'(act_cnt), 32'd8);

        // Empty expectation completes two cycles after the start request.
        start_phase(16'h0000);
        check("t3_rdy1",  32'(recv_rdy),  32'd0);
        check("t3_done1", 32'(recv_done), 32'd0);
        tick;
        check("t3_done2", 32'(recv_done), 32'd1);
        check("t3_rdy2",  32'(recv_rdy),  32'd0);

        // Out-of-range source.
        start_phase(16'h0001);
        base = wq_addr.size();
        send(16'h0054, 16'h5555);
        repeat (4) tick;
        check("t4_nwr",  32'(wq_addr.size() - base), 32'd0);
        check("t4_cnt",  32'(act_cnt),   32'd0);
        check("t4_mask", 32'(done_mask), 32'd0);
        check("t4_err",  32'(recv_err),  32'(EXP_ERR));
        send(16'h8000, 16'h0000);
        wait_done(20);

        // Duplicate completion, then a fresh start clears it.
        start_phase(16'h0018);
        check("t5_err0",  32'(recv_err),  32'd0);
        check("t5_mask0", 32'(done_mask), 32'd0);
        send(16'h8000, 16'h0003);
        send(16'h8000, 16'h0003);
        repeat (3) tick;
        check("t5_err",  32'(recv_err),  32'(EXP_ERR));
        check("t5_mask", 32'(done_mask), 32'h0008);
        send(16'h8000, 16'h0004);
        wait_done(20);
        check("t5_sticky", 32'(recv_err), 32'(EXP_ERR));
        start_phase(16'h0001);
        check("t5_clr_err",  32'(recv_err),  32'd0);
        check("t5_clr_mask", 32'(done_mask), 32'd0);
        check("t5_clr_done", 32'(recv_done), 32'd0);

        // Reset with three entries buffered behind a stalled memory.
        act_wr_stall = 1'b1;
        base = wq_addr.size();
        send(16'h0040, 16'h0B01);
        send(16'h0080, 16'h0B02);
        send(16'h00C0, 16'h0B03);
        rst = 1'b1;
        tick;
        check("t6_rdy",   32'(recv_rdy),  32'd0);
        check("t6_wr_en", 32'(act_wr_en), 32'd0);
        check("t6_addr",  32'(act_wr_addr), 32'd0);
        check("t6_cnt",   32'(act_cnt),   32'd0);
        check("t6_mask",  32'(done_mask), 32'd0);
        check("t6_done",  32'(recv_done), 32'd0);
        check("t6_err",   32'(recv_err),  32'd0);
        act_wr_stall = 1'b0;
        rst = 1'b0;
        repeat (5) tick;
        check("t6_nwr",    32'(wq_addr.size() - base), 32'd0);
        check("t6_wr_en2", 32'(act_wr_en), 32'd0);
        check("t6_rdy2",   32'(recv_rdy),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
